stream_logic_reducer: RTL and testbench
=======================================

// Module: stream_logic_reducer
// PURPOSE
//  Parametrised, clocked successor to the 2-input OR gate: reduces a stream of WIDTH-bit
//  words with a selectable bitwise op (OR/AND/XOR/NOR) over a packet of up to MAX_BEATS
//  beats. Valid/ready on input and output. Sits between a word source and a consumer of
//  per-packet bitwise summaries (flag merge, parity/mask collection).
// PARAMETERS
//  WIDTH      8   data width in bits (>=1)
//  MAX_BEATS  16  max beats per packet (>=1); reaching it without in_last forces packet end
//  CW         derived, $clog2(MAX_BEATS+1); beat-count width (localparam, not overridable)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      synchronous, active-low reset
//  in_valid      in   1      input beat valid
//  in_ready      out  1      block accepts beat; transfer = in_valid & in_ready
//  in_data       in   WIDTH  input word
//  in_last       in   1      final beat of packet
//  op            in   2      00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat only
//  out_valid     out  1      result valid
//  out_ready     in   1      consumer accepts; transfer = out_valid & out_ready
//  out_data      out  WIDTH  reduced result
//  out_count     out  CW     beats in packet (1..MAX_BEATS)
//  out_overflow  out  1      packet forced closed at MAX_BEATS without in_last
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; out_valid=0, out_data=0, out_count=0,
//    out_overflow=0, acc=0, cnt=0, op_q=OR. in_ready=1 the cycle after reset deasserts.
//  - in_ready = ~out_valid (combinational from state). No input accepted while a result is held.
//  - FSM IDLE->ACCUM on first accepted beat without in_last (and MAX_BEATS>1): acc<=in_data,
//    cnt<=1, op_q<=op. ACCUM: each beat acc<=f(op_q,acc,in_data), cnt<=cnt+1.
//  - Closing beat (in_last, or cnt+1==MAX_BEATS) from IDLE or ACCUM -> HOLD; next cycle:
//    out_valid=1, out_data=final acc (inverted if op_q==NOR), out_count=cnt incl. closing beat,
//    out_overflow=1 iff closed by MAX_BEATS with in_last=0. Latency: 1 clk from closing beat.
//  - Single-beat packet: out_data=in_data (NOR: ~in_data), out_count=1.
//  - HOLD: outputs stable until out_ready=1; on transfer -> IDLE, out_valid=0 next cycle,
//    out_overflow cleared; out_data/out_count retain value (don't-care). One bubble per packet.
//  - Beat with in_last exactly at MAX_BEATS: out_overflow=0.
//  - op changes mid-packet ignored; in_valid while in_ready=0 ignored (source must hold).
//  - Reset mid-packet or in HOLD: partial packet/result discarded, all outputs to reset values.
//  - cnt never exceeds MAX_BEATS; no wrap.
// CONFIGURATION
//  REDUCE_PARITY_EN defined: extra port out_parity (out,1) = ^out_data, registered with
//    out_data, reset 0, valid with out_valid. Undefined: port and logic absent; rest identical.
// STRUCTURE
//  - Package stream_logic_pkg: op codes OP_OR/OP_AND/OP_XOR/OP_NOR (2-bit), FSM state
//    encodings ST_IDLE/ST_ACCUM/ST_HOLD.
//  - Sub-module logic_op_unit #(WIDTH): combinational acc/data/op -> next acc
//    (NOR accumulates as OR; inversion applied at output register).
// TESTING (WIDTH=8, MAX_BEATS=4)
//  - rst_n=0 2 clks -> out_valid=0, out_data=0x00, out_count=0, out_overflow=0; in_ready=1 after.
//  - OR: 0x01,0x02,0x80(last) -> 1 clk later out_valid=1, out_data=0x83, count=3, overflow=0.
//  - XOR single beat 0xA5(last) -> 0xA5, count=1; NOR 0x0F,0xF0(last) -> 0x00, count=2;
//    AND 0xFF,0x3C(last) with op toggled to XOR on beat 2 -> 0x3C.
//  - OR 5 beats 0x01,0x02,0x04,0x08,0x10, no last -> after beat 4: 0x0F, count=4,
//    overflow=1; beat 5 (after drain) opens new packet.
//  - out_ready=0 for 5 clks on held result -> out_valid/out_data stable, in_ready=0,
//    in_valid beats not consumed; out_ready=1 -> in_ready=1 next clk.
//  - rst_n=0 after 2 beats of AND 0xF0,0x30 -> then OR 0x01(last) gives 0x01, count=1;
//    with REDUCE_PARITY_EN: 0x83 -> out_parity=1, 0x0F -> 0.

Source files
------------

// File: rtl/stream_logic_pkg.sv
// Shared operation codes and FSM state encodings for the stream logic reducer.
package stream_logic_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACCUM = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise combine of accumulator and incoming word.
// NOR accumulates as OR; the final inversion is applied when the result is registered.
module logic_op_unit
  import stream_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = acc | data;
    case (op)
      OP_AND:  result = acc & data;
      OP_XOR:  result = acc ^ data;
      default: result = acc | data;
    endcase
  end

endmodule

// File: rtl/stream_logic_reducer.sv
// Reduces a packet of WIDTH-bit beats with OR/AND/XOR/NOR into one registered summary word.
// Optional REDUCE_PARITY_EN adds out_parity (= ^out_data), registered alongside out_data.
module stream_logic_reducer
  import stream_logic_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  MAX_BEATS = 16,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
`ifdef REDUCE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [1:0]       op_eff;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] comb_acc;
  logic [WIDTH-1:0] red;
  logic [WIDTH-1:0] final_word;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic             first;
  logic             closing;

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = ~out_valid;
  assign accept    = in_valid & in_ready;
  assign first     = (state == ST_IDLE);

  // The first beat seeds the accumulator and fixes the op for the whole packet.
  assign op_eff  = first ? op : op_q;
  assign cnt_nxt = first ? CW'(1) : cnt + CW'(1);
  assign closing = in_last | (cnt_nxt == CW'(MAX_BEATS));

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .acc    (acc),
    .data   (in_data),
    .op     (op_q),
    .result (comb_acc)
  );

  assign red        = first ? in_data : comb_acc;
  assign final_word = (op_eff == OP_NOR) ? ~red : red;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_OR;
      acc          <= '0;
      cnt          <= '0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
`ifdef REDUCE_PARITY_EN
      out_parity   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (first) op_q <= op;
            acc <= red;
            if (closing) begin
              state        <= ST_HOLD;
              cnt          <= '0;
              out_data     <= final_word;
              out_count    <= cnt_nxt;
              // Closing without in_last can only mean the beat limit was hit.
              out_overflow <= ~in_last;
`ifdef REDUCE_PARITY_EN
              out_parity   <= ^final_word;
`endif
            end else begin
              state <= ST_ACCUM;
              cnt   <= cnt_nxt;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state        <= ST_IDLE;
            out_overflow <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_logic_reducer.sv
// Self-checking bench for stream_logic_reducer (WIDTH=8, MAX_BEATS=4): directed table,
// corner sequences, then randomized traffic against a packet-level reference model.
module tb_stream_logic_reducer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       out_overflow;
`ifdef REDUCE_PARITY_EN
  logic       out_parity;
`endif

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  stream_logic_reducer #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_overflow (out_overflow)
`ifdef REDUCE_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat at the falling edge, hold until accepted, drop valid after the edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic [1:0] o);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    op       = o;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input int n, input logic ovf);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, out_count, n);
    chk({tag, "_ovf"}, out_overflow, ovf);
`ifdef REDUCE_PARITY_EN
    chk({tag, "_parity"}, out_parity, ^d);
`endif
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 1);
    chk({tag, "_drain_ovf"}, out_overflow, 0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [1:0]      op2;
    int              n;
    logic [3:0][7:0] d;
    logic            last;
    logic [7:0]      exp_d;
    int              exp_n;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[7];

  // Reference model: collect whole packets, reduce them once closed.
  typedef struct {
    logic [7:0] d;
    int         n;
    logic       ovf;
  } res_t;

  res_t       expq[$];
  logic [7:0] pkt[$];
  logic [1:0] pkt_op;

  function automatic logic [7:0] reduce(input logic [1:0] o, input logic [7:0] q[$]);
    logic [7:0] r;
    r = q[0];
    for (int i = 1; i < q.size(); i++) begin
      if (o == 2'b01)      r = r & q[i];
      else if (o == 2'b10) r = r ^ q[i];
      else                 r = r | q[i];
    end
    return (o == 2'b11) ? ~r : r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rnd_in_ready", in_ready, expq.size() == 0);
      chk("rnd_out_valid", out_valid, expq.size() != 0);
      if (out_valid && out_ready && expq.size() != 0) begin
        chk("rnd_data", out_data, expq[0].d);
        chk("rnd_count", out_count, expq[0].n);
        chk("rnd_ovf", out_overflow, expq[0].ovf);
        void'(expq.pop_front());
      end
      if (in_valid && in_ready) begin
        if (pkt.size() == 0) pkt_op = op;
        pkt.push_back(in_data);
        if (in_last || pkt.size() == 4) begin
          expq.push_back('{d: reduce(pkt_op, pkt), n: pkt.size(), ovf: !in_last});
          pkt.delete();
        end
      end
    end
  end

  initial begin
    bit acc_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    op        = 2'b00;
    out_ready = 1'b0;

    vecs[0] = '{op: 2'b00, op2: 2'b00, n: 3, d: {8'h00, 8'h80, 8'h02, 8'h01}, last: 1'b1,
                exp_d: 8'h83, exp_n: 3, exp_ovf: 1'b0};
    vecs[1] = '{op: 2'b10, op2: 2'b10, n: 1, d: {8'h00, 8'h00, 8'h00, 8'hA5}, last: 1'b1,
                exp_d: 8'hA5, exp_n: 1, exp_ovf: 1'b0};
    vecs[2] = '{op: 2'b11, op2: 2'b11, n: 2, d: {8'h00, 8'h00, 8'hF0, 8'h0F}, last: 1'b1,
                exp_d: 8'h00, exp_n: 2, exp_ovf: 1'b0};
    vecs[3] = '{op: 2'b01, op2: 2'b10, n: 2, d: {8'h00, 8'h00, 8'h3C, 8'hFF}, last: 1'b1,
                exp_d: 8'h3C, exp_n: 2, exp_ovf: 1'b0};
    vecs[4] = '{op: 2'b01, op2: 2'b01, n: 4, d: {8'h30, 8'h70, 8'hF0, 8'hF0}, last: 1'b1,
                exp_d: 8'h30, exp_n: 4, exp_ovf: 1'b0};
    vecs[5] = '{op: 2'b11, op2: 2'b00, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h0F}, last: 1'b1,
                exp_d: 8'hF0, exp_n: 1, exp_ovf: 1'b0};
    vecs[6] = '{op: 2'b10, op2: 2'b00, n: 4, d: {8'h0F, 8'h07, 8'h03, 8'h01}, last: 1'b0,
                exp_d: 8'h0A, exp_n: 4, exp_ovf: 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Table-driven packets
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        send_beat(vecs[v].d[i], (i == vecs[v].n - 1) ? vecs[v].last : 1'b0,
                  (i == 0) ? vecs[v].op : vecs[v].op2);
      check_result($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_n, vecs[v].exp_ovf);
      drain($sformatf("vec%0d", v));
    end

    // Overflow at MAX_BEATS, then a held beat under 5 cycles of backpressure
    send_beat(8'h01, 1'b0, 2'b00);
    send_beat(8'h02, 1'b0, 2'b00);
    send_beat(8'h04, 1'b0, 2'b00);
    send_beat(8'h08, 1'b0, 2'b00);
    check_result("ovf", 8'h0F, 4, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h10;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h0F);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_ovf", out_overflow, 0);
    @(posedge clk);
    #1;
    check_result("beat5", 8'h10, 1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("beat5_drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-packet discards the partial AND reduction
    send_beat(8'hF0, 1'b0, 2'b01);
    send_beat(8'h30, 1'b0, 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 8'h00);
    chk("midrst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(8'h01, 1'b1, 2'b00);
    check_result("after_midrst", 8'h01, 1, 1'b0);

    // Reset while a result is held
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("holdrst_valid", out_valid, 0);
    chk("holdrst_ready", in_ready, 1);
    chk("holdrst_data", out_data, 8'h00);
    chk("holdrst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with backpressure and mid-packet op changes
    @(negedge clk);
    pkt.delete();
    expq.delete();
    mon_en = 1'b1;
    acc_seen = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc_seen || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_last  = ($urandom_range(0, 3) == 0);
      end
      op = 2'($urandom);
      @(negedge clk);
      acc_seen = in_valid && in_ready;
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("rnd_all_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
